dcache_load_ctrl: RTL and testbench

- Single-port load controller that sits directly upstream of the tag compare/arbiter stage in the std data cache.
- Takes a CPU load as a two-phase request: index first, physical tag one cycle or more later.
- Drives an all-ways array request and consumes the per-way hit vector and line data returned one cycle after grant.
- Returns the selected 64-bit word on a hit; on a miss, hands the line address to the miss handler and replays the lookup once the refill is done.

---
 rtl/dcache_load_ctrl.sv | 163 ++++++++++++++++
 tb/tb_dcache_load_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_load_ctrl.sv
// Two-phase (index, then tag) load controller in front of the dcache tag compare stage.
// Define DCACHE_LOAD_CTRL_PERF_EN to add the hit_cnt_o / miss_cnt_o performance counters.
//
// state      | meaning
// IDLE       | waiting for a CPU load; array request follows req_i
// WAIT_TAG   | index granted; array output usable only in the first cycle
// MISS_REQ   | miss request held stable until the miss handler grants it
// MISS_WAIT  | waiting for the refill to complete
// REPLAY     | re-issuing the array lookup with the latched index
// REPLAY_CMP | comparing the replayed lookup against the latched tag
module dcache_load_ctrl #(
  parameter int ADDR_WIDTH   = 64,
  parameter int SET_ASSOC    = 8,
  parameter int INDEX_WIDTH  = 12,
  parameter int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH,
  parameter int LINE_WIDTH   = 128,
  parameter int OFFSET_WIDTH = $clog2(LINE_WIDTH / 8)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            req_i,
  input  logic [INDEX_WIDTH-1:0]          index_i,
  output logic                            gnt_o,
  input  logic                            tag_valid_i,
  input  logic [TAG_WIDTH-1:0]            tag_i,
  input  logic                            kill_i,
  output logic                            rvalid_o,
  output logic [63:0]                     rdata_o,
  output logic [SET_ASSOC-1:0]            arr_req_o,
  output logic [INDEX_WIDTH-1:0]          arr_addr_o,
  input  logic                            arr_gnt_i,
  output logic [TAG_WIDTH-1:0]            arr_tag_o,
  input  logic [SET_ASSOC-1:0]            hit_way_i,
  input  logic [SET_ASSOC*LINE_WIDTH-1:0] line_data_i,
  output logic                            miss_req_o,
  output logic [ADDR_WIDTH-1:0]           miss_addr_o,
  input  logic                            miss_gnt_i,
  input  logic                            miss_done_i
`ifdef DCACHE_LOAD_CTRL_PERF_EN
  ,
  output logic [31:0]                     hit_cnt_o,
  output logic [31:0]                     miss_cnt_o
`endif
);

  localparam int WORDS = LINE_WIDTH / 64;

  typedef enum logic [2:0] {
    IDLE, WAIT_TAG, MISS_REQ, MISS_WAIT, REPLAY, REPLAY_CMP
  } state_e;

  state_e                 state_q;
  logic [INDEX_WIDTH-1:0] index_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic                   first_q;
  logic                   kill_q;

  logic                   hit;
  logic                   first_cmp;
  logic                   cmp_cycle;
  logic                   miss_enter;
  logic [INDEX_WIDTH-1:0] word_idx;
  logic [63:0]            sel_word;

  assign hit        = |hit_way_i;
  assign first_cmp  = (state_q == WAIT_TAG) && first_q && tag_valid_i;
  assign cmp_cycle  = first_cmp || (state_q == REPLAY_CMP);
  assign miss_enter = cmp_cycle && !kill_i && !hit;
  assign word_idx   = (index_q >> 3) & INDEX_WIDTH'(WORDS - 1);

  // AND-OR mux over the ways: a multi-hit yields the OR of the selected words
  always_comb begin
    sel_word = '0;
    for (int w = 0; w < SET_ASSOC; w++) begin
      if (hit_way_i[w]) sel_word |= line_data_i[w*LINE_WIDTH + 64*int'(word_idx) +: 64];
    end
  end

  // Outputs are decoded from state: grant, tag and hit all complete within the input cycle
  assign gnt_o       = (state_q == IDLE) && req_i && arr_gnt_i;
  assign arr_req_o   = (((state_q == IDLE) && req_i) || (state_q == REPLAY)) ? '1 : '0;
  assign arr_addr_o  = ((state_q == IDLE) && req_i) ? index_i :
                       (state_q == REPLAY)          ? index_q : '0;
  assign arr_tag_o   = first_cmp                    ? tag_i :
                       (state_q == REPLAY_CMP)      ? tag_q : '0;
  assign rvalid_o    = cmp_cycle && hit && !kill_i;
  assign rdata_o     = rvalid_o ? sel_word : '0;
  assign miss_req_o  = (state_q == MISS_REQ);
  assign miss_addr_o = miss_req_o ?
                       {tag_q, index_q[INDEX_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}} : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      index_q <= '0;
      tag_q   <= '0;
      first_q <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i && arr_gnt_i) begin
            index_q <= index_i;
            first_q <= 1'b1;
            state_q <= WAIT_TAG;
          end
        end
        WAIT_TAG: begin
          first_q <= 1'b0;
          if (kill_i) begin
            state_q <= IDLE;
          end else if (tag_valid_i) begin
            tag_q <= tag_i;
            if (!first_q)  state_q <= REPLAY;
            else if (hit)  state_q <= IDLE;
            else           state_q <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          // the request is never withdrawn; a kill is only remembered
          if (kill_i)     kill_q  <= 1'b1;
          if (miss_gnt_i) state_q <= MISS_WAIT;
        end
        MISS_WAIT: begin
          if (miss_done_i) begin
            kill_q  <= 1'b0;
            state_q <= (kill_q || kill_i) ? IDLE : REPLAY;
          end else if (kill_i) begin
            kill_q <= 1'b1;
          end
        end
        REPLAY: begin
          if (kill_i)         state_q <= IDLE;
          else if (arr_gnt_i) state_q <= REPLAY_CMP;
        end
        REPLAY_CMP: begin
          if (kill_i || hit) state_q <= IDLE;
          else               state_q <= MISS_REQ;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_LOAD_CTRL_PERF_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (rvalid_o)   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_enter) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_load_ctrl.sv
// Directed bench for dcache_load_ctrl: hit, grant stall, miss/replay, late tag, kill, reset.
module tb_dcache_load_ctrl;

  localparam int SA = 8;
  localparam int LW = 128;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           req_i;
  logic [11:0]    index_i;
  logic           gnt_o;
  logic           tag_valid_i;
  logic [51:0]    tag_i;
  logic           kill_i;
  logic           rvalid_o;
  logic [63:0]    rdata_o;
  logic [SA-1:0]  arr_req_o;
  logic [11:0]    arr_addr_o;
  logic           arr_gnt_i;
  logic [51:0]    arr_tag_o;
  logic [SA-1:0]  hit_way_i;
  logic [SA*LW-1:0] line_data_i;
  logic           miss_req_o;
  logic [63:0]    miss_addr_o;
  logic           miss_gnt_i;
  logic           miss_done_i;
`ifdef DCACHE_LOAD_CTRL_PERF_EN
  logic [31:0]    hit_cnt_o;
  logic [31:0]    miss_cnt_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  dcache_load_ctrl dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .index_i     (index_i),
    .gnt_o       (gnt_o),
    .tag_valid_i (tag_valid_i),
    .tag_i       (tag_i),
    .kill_i      (kill_i),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .arr_req_o   (arr_req_o),
    .arr_addr_o  (arr_addr_o),
    .arr_gnt_i   (arr_gnt_i),
    .arr_tag_o   (arr_tag_o),
    .hit_way_i   (hit_way_i),
    .line_data_i (line_data_i),
    .miss_req_o  (miss_req_o),
    .miss_addr_o (miss_addr_o),
    .miss_gnt_i  (miss_gnt_i),
    .miss_done_i (miss_done_i)
`ifdef DCACHE_LOAD_CTRL_PERF_EN
    ,
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // inputs change 1ns after the rising edge, outputs are sampled 1ns later
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    req_i       = 1'b0;
    index_i     = '0;
    tag_valid_i = 1'b0;
    tag_i       = '0;
    kill_i      = 1'b0;
    arr_gnt_i   = 1'b0;
    hit_way_i   = '0;
    miss_gnt_i  = 1'b0;
    miss_done_i = 1'b0;
  endtask

  task automatic grant(input logic [11:0] idx);
    idle_inputs();
    req_i = 1'b1; index_i = idx; arr_gnt_i = 1'b1;
    settle();
    check("grant_gnt", gnt_o, 1'b1);
    tick();
  endtask

  initial begin
    idle_inputs();
    line_data_i = '0;
    line_data_i[2*LW +: LW] = 128'hAAAA_BBBB_CCCC_DDDD_1111_2222_3333_4444;
    line_data_i[0*LW +: LW] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    rst_ni = 1'b0;
    #12;
    check("rst_gnt", gnt_o, 1'b0);
    check("rst_rvalid", rvalid_o, 1'b0);
    check("rst_arr_req", arr_req_o, 8'h00);
    check("rst_miss_req", miss_req_o, 1'b0);
    check("rst_rdata", rdata_o, 64'h0);
    check("rst_arr_tag", arr_tag_o, 52'h0);
    check("rst_miss_addr", miss_addr_o, 64'h0);
    #5 rst_ni = 1'b1;
    tick();

    // plain hit, word 1 of way 2
    req_i = 1'b1; index_i = 12'h018; arr_gnt_i = 1'b1;
    settle();
    check("hit_gnt", gnt_o, 1'b1);
    check("hit_arr_req", arr_req_o, 8'hFF);
    check("hit_arr_addr", arr_addr_o, 12'h018);
    tick();
    idle_inputs();
    tag_valid_i = 1'b1; tag_i = 52'h5; hit_way_i = 8'h04;
    settle();
    check("hit_rvalid", rvalid_o, 1'b1);
    check("hit_rdata", rdata_o, 64'hAAAA_BBBB_CCCC_DDDD);
    check("hit_arr_tag", arr_tag_o, 52'h5);
    check("hit_gnt_busy", gnt_o, 1'b0);
    tick();
    idle_inputs();
    settle();
    check("hit_rvalid_pulse", rvalid_o, 1'b0);

    // grant stall for three cycles
    for (int i = 0; i < 3; i++) begin
      req_i = 1'b1; index_i = 12'h018; arr_gnt_i = 1'b0;
      settle();
      check("stall_gnt", gnt_o, 1'b0);
      check("stall_arr_req", arr_req_o, 8'hFF);
      check("stall_arr_addr", arr_addr_o, 12'h018);
      tick();
    end
    grant(12'h018);
    tag_valid_i = 1'b1; tag_i = 52'h5; hit_way_i = 8'h04;
    settle();
    check("stall_rvalid", rvalid_o, 1'b1);
    check("stall_rdata", rdata_o, 64'hAAAA_BBBB_CCCC_DDDD);
    tick();

    // miss, refill, replay hit in way 0
    grant(12'h018);
    tag_valid_i = 1'b1; tag_i = 52'h5; hit_way_i = 8'h00;
    settle();
    check("miss_rvalid", rvalid_o, 1'b0);
    tick();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      settle();
      check("miss_req_held", miss_req_o, 1'b1);
      check("miss_addr", miss_addr_o, 64'h5010);
      tick();
    end
    miss_gnt_i = 1'b1;
    settle();
    check("miss_req_gnt", miss_req_o, 1'b1);
    tick();
    idle_inputs();
    settle();
    check("miss_wait_req", miss_req_o, 1'b0);
    check("miss_wait_arr", arr_req_o, 8'h00);
    tick();
    miss_done_i = 1'b1;
    tick();
    idle_inputs();
    settle();
    check("replay_arr_req", arr_req_o, 8'hFF);
    check("replay_arr_addr", arr_addr_o, 12'h018);
    check("replay_gnt_o", gnt_o, 1'b0);
    tick();
    arr_gnt_i = 1'b1;
    tick();
    idle_inputs();
    hit_way_i = 8'h01;
    settle();
    check("replay_arr_tag", arr_tag_o, 52'h5);
    check("replay_rvalid", rvalid_o, 1'b1);
    check("replay_rdata", rdata_o, 64'h0123_4567_89AB_CDEF);
    tick();

    // late tag: stale first-cycle data must be ignored
    grant(12'h020);
    hit_way_i = 8'h04;
    settle();
    check("late_first_rvalid", rvalid_o, 1'b0);
    tick();
    idle_inputs();
    tag_valid_i = 1'b1; tag_i = 52'h7; hit_way_i = 8'h04;
    settle();
    check("late_tag_rvalid", rvalid_o, 1'b0);
    tick();
    idle_inputs();
    arr_gnt_i = 1'b1;
    settle();
    check("late_replay_req", arr_req_o, 8'hFF);
    check("late_replay_addr", arr_addr_o, 12'h020);
    tick();
    idle_inputs();
    hit_way_i = 8'h01;
    settle();
    check("late_arr_tag", arr_tag_o, 52'h7);
    check("late_rvalid", rvalid_o, 1'b1);
    check("late_rdata", rdata_o, 64'hFEDC_BA98_7654_3210);
    tick();
    idle_inputs();
`ifdef DCACHE_LOAD_CTRL_PERF_EN
    settle();
    check("perf_hit_cnt", hit_cnt_o, 32'd4);
    check("perf_miss_cnt", miss_cnt_o, 32'd1);
`endif

    // kill in MISS_WAIT: no replay after refill
    grant(12'h018);
    tag_valid_i = 1'b1; tag_i = 52'h9; hit_way_i = 8'h00;
    tick();
    idle_inputs();
    miss_gnt_i = 1'b1;
    tick();
    idle_inputs();
    kill_i = 1'b1;
    tick();
    idle_inputs();
    miss_done_i = 1'b1;
    tick();
    idle_inputs();
    settle();
    check("kill_no_replay", arr_req_o, 8'h00);
    check("kill_no_rvalid", rvalid_o, 1'b0);
    grant(12'h018);

    // kill together with a hit
    tag_valid_i = 1'b1; tag_i = 52'h5; hit_way_i = 8'h04; kill_i = 1'b1;
    settle();
    check("kill_hit_rvalid", rvalid_o, 1'b0);
    check("kill_hit_rdata", rdata_o, 64'h0);
    tick();
    grant(12'h018);
    kill_i = 1'b1;
    tick();
    idle_inputs();

    // async reset while the miss request is up
    grant(12'h018);
    tag_valid_i = 1'b1; tag_i = 52'h5; hit_way_i = 8'h00;
    tick();
    idle_inputs();
    settle();
    check("rstmiss_req_up", miss_req_o, 1'b1);
`ifdef DCACHE_LOAD_CTRL_PERF_EN
    check("perf_hit_cnt2", hit_cnt_o, 32'd4);
    check("perf_miss_cnt2", miss_cnt_o, 32'd3);
`endif
    rst_ni = 1'b0;
    #1;
    check("rstmiss_req_drop", miss_req_o, 1'b0);
    check("rstmiss_addr", miss_addr_o, 64'h0);
`ifdef DCACHE_LOAD_CTRL_PERF_EN
    check("perf_hit_rst", hit_cnt_o, 32'd0);
    check("perf_miss_rst", miss_cnt_o, 32'd0);
`endif
    #3 rst_ni = 1'b1;
    tick();
    grant(12'h018);
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
